// File: rtl/addsub_pkg.sv
// Shared definitions for the nibble-serial adder/subtractor: FSM state
// encodings, the nibble width and a helper that sizes the nibble index.
package addsub_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Index width for n nibbles: ceil(log2(n)), never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nibble_addsub4.sv
// One 4-bit slice of the serial adder/subtractor. B is conditionally
// inverted by sub; the carry-in is explicit so slices chain across cycles.
// c3 is the carry into bit 3, needed for the signed-overflow flag.
module nibble_addsub4
  import addsub_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             c3,
  output logic             cout
);

  logic [NIB_W-1:0] b_x;
  logic [3:0]       low;   // bits 2:0 plus carry into bit 3
  logic [1:0]       high;  // bit 3 plus carry out

  // Add the lower three bits separately so the carry into the MSB is visible.
  always_comb begin
    b_x  = b ^ {NIB_W{sub}};
    low  = {1'b0, a[2:0]} + {1'b0, b_x[2:0]} + {3'b000, cin};
    high = {1'b0, a[3]} + {1'b0, b_x[3]} + {1'b0, low[3]};
    sum  = {high[0], low[2:0]};
    c3   = low[3];
    cout = high[1];
  end

endmodule

// File: rtl/serial_addsub8.sv
// Nibble-serial adder/subtractor. Operands are latched on accept, then one
// nibble per cycle is processed LSB first through a single 4-bit slice, with
// the carry held in a register between cycles. The result is held in DONE
// until the downstream handshake.
module serial_addsub8
  import addsub_pkg::*;
#(
  parameter int N_NIB = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NIB_W*N_NIB-1:0] in_a,
  input  logic [NIB_W*N_NIB-1:0] in_b,
  input  logic                   in_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NIB_W*N_NIB-1:0] out_res,
  output logic                   out_carry,
  output logic                   out_ovf,
  output logic                   out_zero
);

  localparam int W     = NIB_W * N_NIB;
  localparam int IDX_W = idx_width(N_NIB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NIB - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q,     a_d;
  logic [W-1:0]     b_q,     b_d;
  logic             sub_q,   sub_d;
  logic [W-1:0]     res_q,   res_d;
  logic             cflag_q, cflag_d;
  logic             ovf_q,   ovf_d;
  logic             zero_q,  zero_d;
  // Goes high on the first edge after reset release; gates in_ready so the
  // block never advertises readiness while held in reset.
  logic             live_q;

  logic [NIB_W-1:0] nib_a, nib_b, nib_sum;
  logic             nib_c3, nib_cout;

  assign nib_a = a_q[idx_q*NIB_W +: NIB_W];
  assign nib_b = b_q[idx_q*NIB_W +: NIB_W];

  nibble_addsub4 u_nib (
    .a    (nib_a),
    .b    (nib_b),
    .sub  (sub_q),
    .cin  (carry_q),
    .sum  (nib_sum),
    .c3   (nib_c3),
    .cout (nib_cout)
  );

  assign in_ready  = live_q && (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_res   = res_q;
  assign out_carry = cflag_q;
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;

  // Next-state, operand capture and per-nibble datapath update.
  always_comb begin
    // NOTE: every variable gets a default here first, so no path through
    // the case can leave one unassigned and infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    res_d   = res_q;
    cflag_d = cflag_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = in_a;
          b_d     = in_b;
          sub_d   = in_sub;
          idx_d   = '0;
          carry_d = in_sub;  // the +1 of two's-complement negation
          res_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        res_d[idx_q*NIB_W +: NIB_W] = nib_sum;
        carry_d = nib_cout;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;  // index never exceeds N_NIB-1
          cflag_d = nib_cout;
          ovf_d   = nib_c3 ^ nib_cout;
          zero_d  = (res_d == '0);
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything so an aborted
  // operation leaves no visible trace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      res_q   <= '0;
      cflag_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed from the previous state, independent of statement order.
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      res_q   <= res_d;
      cflag_q <= cflag_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      live_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_addsub8.sv
// Directed bench for serial_addsub8 (N_NIB=2). Inputs change and outputs are
// sampled on the falling edge, away from the active rising edge.
module tb_serial_addsub8;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_res;
  logic         out_carry;
  logic         out_ovf;
  logic         out_zero;

  int tests_run    = 0;
  int tests_failed = 0;

  serial_addsub8 #(.N_NIB(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_carry (out_carry),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  // Issue one request from a falling edge and wait for out_valid. lat counts
  // rising edges after the accept edge; capped so the bench never hangs.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input bit toggle, output int lat);
    int guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); @(negedge clk); guard++;
    end
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (toggle) begin
        in_a = W'($urandom); in_b = W'($urandom);
        in_sub = 1'($urandom); in_valid = 1'($urandom);
      end
      @(posedge clk); lat++; @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({out_valid, in_ready, out_res, out_carry, out_ovf, out_zero} !== 13'd0) begin
      $display("FAIL reset_outputs: got v=%b rdy=%b res=%h c=%b o=%b z=%b expected all 0",
               out_valid, in_ready, out_res, out_carry, out_ovf, out_zero);
      tests_failed++;
    end
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_ready: got %b expected 1", in_ready);
      tests_failed++;
    end
  endtask

  task automatic test_add();
    int lat;
    do_op(8'h3C, 8'h0F, 1'b0, 1'b0, lat);
    tests_run++;
    if (lat !== 2) begin
      $display("FAIL add_latency: got %0d expected 2", lat); tests_failed++;
    end
    tests_run++;
    if ({out_res, out_carry, out_ovf, out_zero} !== {8'h4B, 3'b000}) begin
      $display("FAIL add_3c_0f: got res=%h c=%b o=%b z=%b expected res=4b c=0 o=0 z=0",
               out_res, out_carry, out_ovf, out_zero);
      tests_failed++;
    end
    handshake();
  endtask

  task automatic test_overflow();
    int lat;
    do_op(8'h7F, 8'h01, 1'b0, 1'b0, lat);
    tests_run++;
    if ({out_valid, out_res, out_carry, out_ovf, out_zero} !== {1'b1, 8'h80, 3'b010}) begin
      $display("FAIL add_ovf: got v=%b res=%h c=%b o=%b z=%b expected v=1 res=80 c=0 o=1 z=0",
               out_valid, out_res, out_carry, out_ovf, out_zero);
      tests_failed++;
    end
    handshake();
  endtask

  task automatic test_sub();
    int lat;
    do_op(8'h05, 8'h09, 1'b1, 1'b0, lat);
    tests_run++;
    if ({out_valid, out_res, out_carry, out_ovf, out_zero} !== {1'b1, 8'hFC, 3'b000}) begin
      $display("FAIL sub_borrow: got v=%b res=%h c=%b o=%b z=%b expected v=1 res=fc c=0 o=0 z=0",
               out_valid, out_res, out_carry, out_ovf, out_zero);
      tests_failed++;
    end
    handshake();
    do_op(8'h10, 8'h10, 1'b1, 1'b0, lat);
    tests_run++;
    if ({out_valid, out_res, out_carry, out_ovf, out_zero} !== {1'b1, 8'h00, 3'b101}) begin
      $display("FAIL sub_zero: got v=%b res=%h c=%b o=%b z=%b expected v=1 res=00 c=1 o=0 z=1",
               out_valid, out_res, out_carry, out_ovf, out_zero);
      tests_failed++;
    end
    handshake();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad = 0;
    do_op(8'h80, 8'h01, 1'b1, 1'b0, lat);  // 0x80 - 0x01 = 0x7F, no borrow, overflow
    for (int i = 0; i < 5; i++) begin
      if ({out_valid, in_ready, out_res, out_carry, out_ovf, out_zero} !==
          {2'b10, 8'h7F, 3'b110}) bad++;
      @(posedge clk); @(negedge clk);
    end
    tests_run++;
    if (bad != 0) begin
      $display("FAIL hold_done: got %0d unstable cycles, last v=%b rdy=%b res=%h c=%b o=%b expected 0 (v=1 rdy=0 res=7f c=1 o=1)",
               bad, out_valid, in_ready, out_res, out_carry, out_ovf);
      tests_failed++;
    end
    handshake();
    tests_run++;
    if ({out_valid, in_ready} !== 2'b01) begin
      $display("FAIL ready_after_hs: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
      tests_failed++;
    end
  endtask

  task automatic test_reset_during_run();
    int seen = 0;
    int guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); @(negedge clk); guard++;
    end
    in_a = 8'hFF; in_b = 8'h01; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);  // now in the first RUN cycle
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, in_ready, out_res, out_carry, out_ovf, out_zero} !== 13'd0) begin
      $display("FAIL abort_outputs: got v=%b rdy=%b res=%h c=%b o=%b z=%b expected all 0",
               out_valid, in_ready, out_res, out_carry, out_ovf, out_zero);
      tests_failed++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1) begin
      $display("FAIL abort_ready: got %b expected 1", in_ready); tests_failed++;
    end
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b0) seen++;
      @(posedge clk); @(negedge clk);
    end
    tests_run++;
    if (seen != 0 || out_res !== 8'h00) begin
      $display("FAIL abort_no_result: got %0d valid cycles res=%h expected 0 and 00", seen, out_res);
      tests_failed++;
    end
  endtask

  task automatic test_operand_toggle();
    int lat;
    do_op(8'hA5, 8'h3C, 1'b0, 1'b1, lat);
    tests_run++;
    if ({out_res, out_carry, out_ovf, out_zero} !== {8'hE1, 3'b000}) begin
      $display("FAIL toggle_add: got res=%h c=%b o=%b z=%b expected res=e1 c=0 o=0 z=0",
               out_res, out_carry, out_ovf, out_zero);
      tests_failed++;
    end
    handshake();
    do_op(8'hA5, 8'h3C, 1'b1, 1'b1, lat);
    tests_run++;
    if ({out_res, out_carry, out_ovf, out_zero} !== {8'h69, 3'b110}) begin
      $display("FAIL toggle_sub: got res=%h c=%b o=%b z=%b expected res=69 c=1 o=1 z=0",
               out_res, out_carry, out_ovf, out_zero);
      tests_failed++;
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    int lat;
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, lat);
    tests_run++;
    if ({lat, out_res, out_carry, out_ovf, out_zero} !== {32'd2, 8'h00, 3'b101}) begin
      $display("FAIL b2b_first: got lat=%0d res=%h c=%b o=%b z=%b expected lat=2 res=00 c=1 o=0 z=1",
               lat, out_res, out_carry, out_ovf, out_zero);
      tests_failed++;
    end
    handshake();
    do_op(8'h12, 8'h34, 1'b0, 1'b0, lat);
    tests_run++;
    if ({lat, out_res, out_carry, out_ovf, out_zero} !== {32'd2, 8'h46, 3'b000}) begin
      $display("FAIL b2b_second: got lat=%0d res=%h c=%b o=%b z=%b expected lat=2 res=46 c=0 o=0 z=0",
               lat, out_res, out_carry, out_ovf, out_zero);
      tests_failed++;
    end
    handshake();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_add();
    test_overflow();
    test_sub();
    test_backpressure();
    test_reset_during_run();
    test_operand_toggle();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
